// File: rtl/rtc_read_sequencer.sv
// Copies nine RTC registers into the register memory: opens the write window,
// reads each RTC register over a req/ack handshake, writes it, then waits for the memory copy.
module rtc_read_sequencer #(
    parameter int ACK_TIMEOUT   = 64,
    parameter int READY_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       rtc_req,
    output logic [7:0] rtc_addr,
    input  logic       rtc_ack,
    input  logic [7:0] rtc_data,
    output logic [3:0] ADD1,
    output logic [7:0] DAT1,
    output logic       w1,
    output logic       whileT,
    input  logic       actready,
    output logic       busy,
    output logic       err
);

    // state      | meaning
    // IDLE       | waiting for start
    // OPEN       | write window open, two settle cycles before the first read
    // REQ        | present rtc_addr for entry k, load ack timer
    // WAIT_ACK   | rtc_req high until rtc_ack or ack timeout
    // WRITE      | one-cycle w1 strobe with captured data
    // CLOSE      | drop whileT, load ready timer
    // WAIT_READY | wait for actready rising edge or ready timeout
    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_REQ, S_WAIT_ACK, S_WRITE, S_CLOSE, S_WAIT_READY
    } state_t;

    localparam int T_MAX  = (ACK_TIMEOUT > READY_TIMEOUT) ? ACK_TIMEOUT : READY_TIMEOUT;
    localparam int TW_RAW = $clog2(T_MAX + 1);
    localparam int TW     = (TW_RAW < 7) ? 7 : TW_RAW;
    localparam logic [TW-1:0] ACK_LOAD   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] READY_LOAD = TW'(READY_TIMEOUT - 1);
    localparam logic [TW-1:0] OPEN_LOAD  = TW'(1);

    function automatic logic [7:0] rtc_of(input logic [3:0] idx);
        case (idx)
            4'd0:    rtc_of = 8'h21;
            4'd1:    rtc_of = 8'h22;
            4'd2:    rtc_of = 8'h23;
            4'd3:    rtc_of = 8'h24;
            4'd4:    rtc_of = 8'h25;
            4'd5:    rtc_of = 8'h26;
            4'd6:    rtc_of = 8'h41;
            4'd7:    rtc_of = 8'h42;
            4'd8:    rtc_of = 8'h43;
            default: rtc_of = 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] mem_of(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: mem_of = idx;
            4'd6:    mem_of = 4'd8;
            4'd7:    mem_of = 4'd9;
            4'd8:    mem_of = 4'd10;
            default: mem_of = 4'hF;
        endcase
    endfunction

    state_t        state, state_n;
    logic [3:0]    k, k_n;
    logic [TW-1:0] timer, timer_n;
    logic          err_q, err_n;
    logic [7:0]    addr_q, addr_n;
    logic [3:0]    add1_q, add1_n;
    logic [7:0]    dat1_q, dat1_n;
    logic          act_q, act_q2;
    logic          ready_rise;
    logic          last;

    assign ready_rise = act_q & ~act_q2;
    assign last       = (k == 4'd8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            k      <= '0;
            timer  <= '0;
            err_q  <= 1'b0;
            addr_q <= 8'h00;
            add1_q <= 4'hF;
            dat1_q <= 8'h00;
            act_q  <= 1'b0;
            act_q2 <= 1'b0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            timer  <= timer_n;
            err_q  <= err_n;
            addr_q <= addr_n;
            add1_q <= add1_n;
            dat1_q <= dat1_n;
            act_q  <= actready;
            act_q2 <= act_q;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        timer_n = timer;
        err_n   = err_q;
        addr_n  = addr_q;
        add1_n  = add1_q;
        dat1_n  = dat1_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_OPEN;
                    k_n     = '0;
                    err_n   = 1'b0;
                    timer_n = OPEN_LOAD;
                end
            end
            S_OPEN: begin
                if (timer == '0) state_n = S_REQ;
                else             timer_n = timer - 1'b1;
            end
            S_REQ: begin
                addr_n  = rtc_of(k);
                timer_n = ACK_LOAD;
                state_n = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (rtc_ack) begin
                    dat1_n  = rtc_data;
                    add1_n  = mem_of(k);
                    timer_n = '0;
                    state_n = S_WRITE;
                end else if (timer == '0) begin
                    // unanswered entry is skipped without a write
                    err_n = 1'b1;
                    if (last) begin
                        state_n = S_CLOSE;
                    end else begin
                        k_n     = k + 4'd1;
                        state_n = S_REQ;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            S_WRITE: begin
                if (last) begin
                    state_n = S_CLOSE;
                end else begin
                    k_n     = k + 4'd1;
                    state_n = S_REQ;
                end
            end
            S_CLOSE: begin
                timer_n = READY_LOAD;
                state_n = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (ready_rise) begin
                    timer_n = '0;
                    state_n = S_IDLE;
                end else if (timer == '0) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign rtc_req  = (state == S_WAIT_ACK);
    assign w1       = (state == S_WRITE);
    assign whileT   = (state == S_OPEN) || (state == S_REQ) || (state == S_WAIT_ACK) ||
                      (state == S_WRITE) || (state == S_CLOSE);
    assign busy     = (state != S_IDLE);
    assign err      = err_q;
    assign rtc_addr = addr_q;
    assign ADD1     = add1_q;
    assign DAT1     = dat1_q;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed bench for rtc_read_sequencer: an RTC responder pushes expected
// memory writes into a scoreboard that a monitor pops on every w1 strobe.
module tb_rtc_read_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, rtc_ack, actready;
    logic [7:0] rtc_data;
    logic       rtc_req, w1, whileT, busy, err;
    logic [7:0] rtc_addr, DAT1;
    logic [3:0] ADD1;

    rtc_read_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_ack(rtc_ack), .rtc_data(rtc_data),
        .ADD1(ADD1), .DAT1(DAT1), .w1(w1), .whileT(whileT),
        .actready(actready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          wcount   = 0;
    int          skip_k   = -1;
    bit          stray_en = 1'b0;
    int          resp_idx;
    int          w0, n;
    logic [11:0] sbq[$];
    logic [11:0] mon_exp;
    logic [7:0]  rtc_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [3:0]  mem_tab [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [7:0] a);
        for (int i = 0; i < 9; i++) if (rtc_tab[i] == a) return i;
        return -1;
    endfunction

    // RTC responder: ack 3 cycles into each request, data 30h+k
    initial begin
        rtc_ack  = 1'b0;
        rtc_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rtc_req && !reset) begin
                resp_idx = idx_of(rtc_addr);
                check("rtc_addr_valid", 32'(resp_idx >= 0), 32'd1);
                if (resp_idx >= 0 && resp_idx != skip_k) begin
                    repeat (2) @(negedge clk);
                    if (rtc_req && !reset) begin
                        sbq.push_back({mem_tab[resp_idx], 8'h30 + 8'(resp_idx)});
                        rtc_ack  = 1'b1;
                        rtc_data = 8'h30 + 8'(resp_idx);
                        @(negedge clk);
                        rtc_ack  = 1'b0;
                        rtc_data = 8'h00;
                        if (stray_en && w1) begin
                            rtc_ack  = 1'b1;
                            rtc_data = 8'hEE;
                            @(negedge clk);
                            rtc_ack  = 1'b0;
                            rtc_data = 8'h00;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (w1) begin
            wcount++;
            check("req_during_w1", 32'(rtc_req), 32'd0);
            check("whileT_during_w1", 32'(whileT), 32'd1);
            if (sbq.size() == 0) begin
                check("unexpected_w1", 32'(w1), 32'd0);
            end else begin
                mon_exp = sbq.pop_front();
                check("ADD1", 32'(ADD1), 32'(mon_exp[11:8]));
                check("DAT1", 32'(DAT1), 32'(mon_exp[7:0]));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},   32'(busy),     32'd0);
        check({tag, "_whileT"}, 32'(whileT),   32'd0);
        check({tag, "_rtc_req"},32'(rtc_req),  32'd0);
        check({tag, "_addr"},   32'(rtc_addr), 32'h00);
        check({tag, "_w1"},     32'(w1),       32'd0);
        check({tag, "_err"},    32'(err),      32'd0);
        check({tag, "_ADD1"},   32'(ADD1),     32'hF);
        check({tag, "_DAT1"},   32'(DAT1),     32'h00);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        actready = 1'b0;
        check({tag, "_busy_after_start"},   32'(busy),   32'd1);
        check({tag, "_whileT_after_start"}, 32'(whileT), 32'd1);
        check({tag, "_err_after_start"},    32'(err),    32'd0);
    endtask

    task automatic wait_close(input string tag);
        int c = 0;
        while (whileT && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_close_reached"}, 32'(whileT), 32'd0);
    endtask

    task automatic finish_ready(input string tag);
        int c = 0;
        repeat (3) @(negedge clk);
        actready = 1'b1;
        while (busy && c < 10) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_idle_on_ready"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        actready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // nominal sequence
        w0 = wcount;
        do_start("t1");
        wait_close("t1");
        check("t1_writes", 32'(wcount - w0), 32'd9);
        finish_ready("t1");
        check("t1_err", 32'(err), 32'd0);
        check("t1_ADD1_hold", 32'(ADD1), 32'd10);
        check("t1_DAT1_hold", 32'(DAT1), 32'h38);
        check("t1_sb_empty", 32'(sbq.size()), 32'd0);

        // ack timeout on k=2
        skip_k = 2;
        w0 = wcount;
        do_start("t2");
        n = 0;
        while (!(rtc_req && rtc_addr == 8'h23) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (rtc_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t2_ack_wait_cycles", 32'(n), 32'd64);
        check("t2_err_set", 32'(err), 32'd1);
        wait_close("t2");
        check("t2_writes", 32'(wcount - w0), 32'd8);
        finish_ready("t2");
        check("t2_err_sticky", 32'(err), 32'd1);
        check("t2_sb_empty", 32'(sbq.size()), 32'd0);

        // ready timeout
        skip_k = -1;
        do_start("t3");
        wait_close("t3");
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t3_ready_wait_cycles", 32'(n), 32'd64);
        check("t3_err", 32'(err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);

        // reset during WAIT_ACK of k=4, then restart
        actready = 1'b1;
        skip_k = 4;
        do_start("t4");
        n = 0;
        while (!(rtc_req && rtc_addr == 8'h25) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("t4_midreset");
        reset = 1'b0;
        w0 = wcount;
        repeat (10) @(negedge clk);
        check("t4_no_write_after_reset", 32'(wcount - w0), 32'd0);
        check("t4_idle_after_reset", 32'(busy), 32'd0);
        check("t4_sb_empty", 32'(sbq.size()), 32'd0);
        skip_k = -1;
        actready = 1'b1;
        w0 = wcount;
        do_start("t4b");
        wait_close("t4b");
        check("t4b_writes", 32'(wcount - w0), 32'd9);
        finish_ready("t4b");

        // start pulses and stray acks while busy
        stray_en = 1'b1;
        w0 = wcount;
        do_start("t5");
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_close("t5");
        stray_en = 1'b0;
        finish_ready("t5");
        repeat (20) @(negedge clk);
        check("t5_no_second_seq", 32'(busy), 32'd0);
        check("t5_writes", 32'(wcount - w0), 32'd9);
        check("t5_sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_read_sequencer.md
RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT, default 64, max clk cycles waiting for rtc_ack per register.
REQ-002 Parameter READY_TIMEOUT, default 64, max clk cycles waiting for actready after whileT drops.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to refresh the RTC register memory; ignored unless IDLE.
REQ-007 rtc_req  out  1  read request to RTC bus interface; level, held until rtc_ack.
REQ-008 rtc_addr  out  8  RTC register address for current read.
REQ-009 rtc_ack  in  1  one-cycle acknowledge; rtc_data valid in same cycle.
REQ-010 rtc_data  in  8  RTC read data (BCD, passed unmodified).
REQ-011 ADD1  out  4  register-memory write address.
REQ-012 DAT1  out  8  register-memory write data.
REQ-013 w1  out  1  register-memory write strobe, one cycle per register.
REQ-014 whileT  out  1  write-window flag to register memory; high for entire sequence.
REQ-015 actready  in  1  register memory copy-complete flag (cleared by memory when window opens, set when copy done).
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err  out  1  sticky timeout flag; cleared only by reset or by next start.

Function
REQ-018 Fixed table, 9 entries, index k=0..8 -> (mem addr, rtc addr): (0,21h) (1,22h) (2,23h) (3,24h) (4,25h) (5,26h) (8,41h) (9,42h) (10,43h); mem addr 12 and all others never written.
REQ-019 States: IDLE, OPEN, REQ, WAIT_ACK, WRITE, CLOSE, WAIT_READY; 4-bit index k, timeout counter >= 7 bits.
REQ-020 IDLE: start=1 -> OPEN, k<=0, err<=0, whileT<=1.
REQ-021 OPEN: hold 2 cycles with whileT=1, no writes, then -> REQ (lets memory reach its write state).
REQ-022 REQ: rtc_addr<=table[k].rtc, rtc_req<=1, timer<=0 -> WAIT_ACK.
REQ-023 WAIT_ACK: rtc_ack=1 -> capture rtc_data, ADD1<=table[k].mem, rtc_req<=0 -> WRITE; timer reaches ACK_TIMEOUT -> err<=1, rtc_req<=0, skip entry (no write), advance k as in WRITE.
REQ-024 WRITE: DAT1=captured data, w1=1 for exactly one cycle; k==8 -> CLOSE, else k<=k+1 -> REQ.
REQ-025 Per-register latency: ack latency + 2 cycles; rtc_req never asserted while w1=1.
REQ-026 CLOSE: whileT<=0, timer<=0 -> WAIT_READY.
REQ-027 WAIT_READY: 0->1 edge of actready (registered copy) -> IDLE; timer reaches READY_TIMEOUT -> err<=1 -> IDLE.
REQ-028 ADD1/DAT1 SHALL hold last written values outside WRITE (memory rewrites them while idle; rewrite must be idempotent).
REQ-029 start while busy SHALL be ignored, not queued.
REQ-030 rtc_ack outside WAIT_ACK SHALL be ignored.
REQ-031 start and timeout in same cycle: timeout handled, start ignored.

Reset
REQ-032 reset=1 at any edge, including mid-sequence: state IDLE, k=0, timers=0, rtc_req=0, rtc_addr=00h, w1=0, whileT=0, busy=0, err=0, ADD1=4'hF, DAT1=00h; partial sequence abandoned, no further writes.
REQ-033 Reset takes priority over start and rtc_ack in the same cycle.

Verification
REQ-034 Nominal: start, ack 3 cycles after each req with data 30h..38h -> 9 w1 pulses, (ADD1,DAT1)=(0,30h)..(10,38h) in table order, whileT high from cycle after start until after 9th write, IDLE on actready edge.
REQ-035 Ack timeout: no ack for k=2 -> after 64 cycles err=1, no write to addr 2, remaining 8 writes occur, err stays 1 in IDLE.
REQ-036 Ready timeout: actready held 0 -> WAIT_READY exits after 64 cycles, err=1, busy=0.
REQ-037 Reset mid-sequence: reset during WAIT_ACK of k=4 -> next cycle all outputs at REQ-032 values, no w1; following start restarts at k=0.
REQ-038 Busy start / stray ack: start pulses and rtc_ack during sequence -> no second sequence, exactly 9 writes, no extra w1.
